// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, optional two-entry skid buffer, flush and NOP bubbles
module pipe_stage_reg #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 101,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic              main_valid, skid_valid, acc, main_free;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  assign in_ready  = SKID ? (rst | ~skid_valid) : (~main_valid | out_ready);
  assign acc       = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = {main_valid & skid_valid, main_valid ^ skid_valid};
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_free) begin
        main_valid <= skid_valid | acc;
        if (skid_valid) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end else if (acc) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end
      end
      // skid only fills while the head is held; it drains into main as soon as main frees
      skid_valid <= SKID && !main_free && (skid_valid || acc);
      if (SKID && !main_free && acc) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table for SKID=1 plus a hand sequence for SKID=0
module tb_pipe_stage_reg;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic         in_valid = 0, flush = 0, out_ready = 0;
  logic         in_ready, out_valid;
  logic [5:0]   in_ctrl = '0, out_ctrl;
  logic [100:0] in_data = '0, out_data;
  logic [1:0]   occupancy;
  logic         z_iv = 0, z_ordy = 0, z_ir, z_ov;
  logic [5:0]   z_ic = '0, z_oc;
  logic [100:0] z_id = '0, z_od;
  logic [1:0]   z_occ;
  int total = 0, bad = 0;
  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );
  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(z_iv), .in_ready(z_ir), .in_ctrl(z_ic),
    .in_data(z_id), .flush(1'b0), .out_valid(z_ov), .out_ready(z_ordy),
    .out_ctrl(z_oc), .out_data(z_od), .occupancy(z_occ)
  );
  typedef struct {
    logic r, f, iv;
    logic [5:0] ic;
    logic [100:0] id;
    logic ordy, ev;
    logic [5:0] ec;
    logic [100:0] ed;
    logic [1:0] eo;
    logic eir;
  } vec_t;
  vec_t v[23];
  function automatic vec_t mk(logic r, logic f, logic iv, logic [5:0] ic, int id, logic ordy,
                              logic ev, logic [5:0] ec, int ed, logic [1:0] eo, logic eir);
    vec_t t;
    t.r = r; t.f = f; t.iv = iv; t.ic = ic; t.id = 101'(id); t.ordy = ordy;
    t.ev = ev; t.ec = ec; t.ed = 101'(ed); t.eo = eo; t.eir = eir;
    return t;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    //        r  f  iv ic     id     rdy ev ec     ed     eo ir
    v[0]  = mk(1, 0, 0, 6'h00, 'h00, 0,  0, 6'h00, 'h00, 0, 1);
    v[1]  = mk(1, 0, 1, 6'h3f, 'h55, 1,  0, 6'h00, 'h00, 0, 1);
    v[2]  = mk(0, 0, 1, 6'h01, 'h10, 1,  1, 6'h01, 'h10, 1, 1);
    v[3]  = mk(0, 0, 1, 6'h02, 'h11, 1,  1, 6'h02, 'h11, 1, 1);
    v[4]  = mk(0, 0, 1, 6'h03, 'h12, 1,  1, 6'h03, 'h12, 1, 1);
    v[5]  = mk(0, 0, 1, 6'h04, 'h13, 1,  1, 6'h04, 'h13, 1, 1);
    v[6]  = mk(0, 0, 0, 6'h00, 'h00, 1,  0, 6'h00, 'h13, 0, 1);
    v[7]  = mk(0, 0, 1, 6'h05, 'h20, 0,  1, 6'h05, 'h20, 1, 1);
    v[8]  = mk(0, 0, 1, 6'h06, 'h21, 0,  1, 6'h05, 'h20, 2, 0);
    v[9]  = mk(0, 0, 1, 6'h07, 'h22, 0,  1, 6'h05, 'h20, 2, 0);
    v[10] = mk(0, 0, 1, 6'h07, 'h22, 1,  1, 6'h06, 'h21, 1, 1);
    v[11] = mk(0, 0, 1, 6'h07, 'h22, 1,  1, 6'h07, 'h22, 1, 1);
    v[12] = mk(0, 0, 0, 6'h00, 'h00, 1,  0, 6'h00, 'h22, 0, 1);
    v[13] = mk(0, 0, 1, 6'h3f, 'h30, 1,  1, 6'h3f, 'h30, 1, 1);
    v[14] = mk(0, 0, 0, 6'h00, 'h00, 1,  0, 6'h00, 'h30, 0, 1);
    v[15] = mk(0, 0, 1, 6'h08, 'h40, 0,  1, 6'h08, 'h40, 1, 1);
    v[16] = mk(0, 0, 1, 6'h09, 'h41, 0,  1, 6'h08, 'h40, 2, 0);
    v[17] = mk(0, 1, 1, 6'h0a, 'h42, 0,  0, 6'h00, 'h40, 0, 1);
    v[18] = mk(0, 0, 1, 6'h0b, 'h43, 0,  1, 6'h0b, 'h43, 1, 1);
    v[19] = mk(0, 0, 1, 6'h0c, 'h44, 0,  1, 6'h0b, 'h43, 2, 0);
    v[20] = mk(1, 1, 1, 6'h0d, 'h45, 1,  0, 6'h00, 'h00, 0, 1);
    v[21] = mk(0, 0, 1, 6'h0e, 'h46, 0,  1, 6'h0e, 'h46, 1, 1);
    v[22] = mk(0, 0, 0, 6'h00, 'h00, 1,  0, 6'h00, 'h46, 0, 1);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = v[i].r; flush = v[i].f; in_valid = v[i].iv;
      in_ctrl = v[i].ic; in_data = v[i].id; out_ready = v[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(v[i].ev));
      chk($sformatf("v%0d out_ctrl", i), 128'(out_ctrl), 128'(v[i].ec));
      chk($sformatf("v%0d out_data", i), 128'(out_data), 128'(v[i].ed));
      chk($sformatf("v%0d occupancy", i), 128'(occupancy), 128'(v[i].eo));
      chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(v[i].eir));
    end
    @(negedge clk);
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    z_iv = 1; z_ic = 6'h01; z_id = 101'h50; z_ordy = 0;
    @(posedge clk);
    #1;
    chk("s0 hold occupancy", 128'(z_occ), 128'(1));
    chk("s0 hold in_ready", 128'(z_ir), 128'(0));
    chk("s0 hold out_ctrl", 128'(z_oc), 128'(6'h01));
    @(negedge clk);
    z_ic = 6'h02; z_id = 101'h51; z_ordy = 1;
    #1;
    chk("s0 pass in_ready", 128'(z_ir), 128'(1));
    @(posedge clk);
    #1;
    chk("s0 replace out_data", 128'(z_od), 128'(101'h51));
    chk("s0 replace out_ctrl", 128'(z_oc), 128'(6'h02));
    chk("s0 replace occupancy", 128'(z_occ), 128'(1));
    @(negedge clk);
    z_iv = 0;
    @(posedge clk);
    #1;
    chk("s0 drain out_valid", 128'(z_ov), 128'(0));
    chk("s0 drain occupancy", 128'(z_occ), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
